// File: rtl/led_out_arbiter.sv
// led_out_arbiter
//   Shares the single 4-bit LED output register among N_REQ nibble producers.
//   A round-robin search picks one requester per arbitration. The arbiter then
//   holds off further grants for HOLD_CYCLES cycles, so each nibble stays
//   visible on the LEDs for a minimum time.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   req        per-requester request, level-held until ack
//   data       nibble per requester, requester i on bits [4i+3:4i]
//   ack        one-hot, one-cycle grant pulse
//   ff_enable  enable for the LED output register (high during GRANT)
//   ff_D       data for the LED output register (holds last granted nibble)
//   busy       high during GRANT and HOLD
//   last_src   index of the most recently granted requester
module led_out_arbiter #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CW          = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] data,
  output logic [N_REQ-1:0]   ack,
  output logic               ff_enable,
  output logic [3:0]         ff_D,
  output logic               busy,
  output logic [2:0]         last_src
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       rr_ptr, rr_nxt;
  logic [CW-1:0]    hold_cnt, hold_nxt;
  logic [N_REQ-1:0] ack_nxt;
  logic             en_nxt;
  logic [3:0]       d_nxt;
  logic             busy_nxt;
  logic [2:0]       src_nxt;
  logic             found;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    hold_nxt  = hold_cnt;
    ack_nxt   = '0;
    en_nxt    = 1'b0;
    d_nxt     = ff_D;
    busy_nxt  = busy;
    src_nxt   = last_src;
    found     = 1'b0;

    case (state)
      IDLE: begin
        // Search order is rr_ptr, rr_ptr+1, ... wrapping at N_REQ. The outer
        // loop walks the priority order; the inner loop uses a constant index
        // so the selection needs no variable bit-select.
        for (int k = 0; k < N_REQ; k++) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (i == ((int'(rr_ptr) + k) % N_REQ))) begin
              found      = 1'b1;
              src_nxt    = 3'(i);
              d_nxt      = data[4*i +: 4];
              ack_nxt[i] = 1'b1;
            end
          end
        end
        if (found) begin
          state_nxt = GRANT;
          en_nxt    = 1'b1;
          busy_nxt  = 1'b1;
        end
      end

      GRANT: begin
        // The winner moves to lowest priority for the next arbitration.
        rr_nxt = (last_src == 3'(N_REQ - 1)) ? 3'd0 : last_src + 3'd1;
        if (HOLD_CYCLES > 0) begin
          state_nxt = HOLD;
          hold_nxt  = CW'(HOLD_CYCLES - 1);
        end else begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      end

      HOLD: begin
        // req is deliberately not looked at here.
        if (hold_cnt == '0) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          hold_nxt = hold_cnt - CW'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= 3'd0;
      hold_cnt  <= '0;
      ack       <= '0;
      ff_enable <= 1'b0;
      ff_D      <= 4'b0000;
      busy      <= 1'b0;
      last_src  <= 3'd0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      hold_cnt  <= hold_nxt;
      ack       <= ack_nxt;
      ff_enable <= en_nxt;
      ff_D      <= d_nxt;
      busy      <= busy_nxt;
      last_src  <= src_nxt;
    end
  end

endmodule

// File: tb/tb_led_out_arbiter.sv
module tb_led_out_arbiter;

  logic        clk;
  logic        reset;

  // Default build: N_REQ=4, HOLD_CYCLES=8
  logic [3:0]  req;
  logic [15:0] data;
  logic [3:0]  ack;
  logic        ff_enable;
  logic [3:0]  ff_D;
  logic        busy;
  logic [2:0]  last_src;

  // Zero-hold build
  logic [3:0]  req0;
  logic [15:0] data0;
  logic [3:0]  ack0;
  logic        en0;
  logic [3:0]  d0;
  logic        busy0;
  logic [2:0]  src0;

  int total;
  int passed;
  int cyc;

  led_out_arbiter #(.N_REQ(4), .HOLD_CYCLES(8), .CW(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .ff_enable(ff_enable),
    .ff_D     (ff_D),
    .busy     (busy),
    .last_src (last_src)
  );

  led_out_arbiter #(.N_REQ(4), .HOLD_CYCLES(0), .CW(8)) dut0 (
    .clk      (clk),
    .reset    (reset),
    .req      (req0),
    .data     (data0),
    .ack      (ack0),
    .ff_enable(en0),
    .ff_D     (d0),
    .busy     (busy0),
    .last_src (src0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Bounded wait for any ack pulse.
  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (ack != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit         ok;
    int         last_cyc;
    logic [3:0] exp_ack;

    total = 0;
    passed = 0;
    cyc = 0;
    reset = 1'b1;
    req = 4'b0000;
    data = 16'h0000;
    req0 = 4'b0000;
    data0 = 16'h0000;

    // Power-on reset
    repeat (2) step();
    check("reset_outs", {ack, ff_enable, ff_D, busy, last_src}, 13'd0);
    check("reset_outs0", {ack0, en0, d0, busy0, src0}, 13'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single request from requester 2
    data = 16'h0A00;
    req = 4'b0100;
    step();
    check("single_ack", ack, 4'b0100);
    check("single_en", ff_enable, 1'b1);
    check("single_D", ff_D, 4'hA);
    check("single_src", last_src, 3'd2);
    check("single_busy", busy, 1'b1);
    req = 4'b0000;
    for (int n = 0; n < 8; n++) begin
      step();
      check("single_hold", {busy, ack, ff_enable, ff_D}, {1'b1, 4'b0000, 1'b0, 4'hA});
    end
    step();
    check("single_idle", {busy, ack, ff_enable, ff_D}, {1'b0, 4'b0000, 1'b0, 4'hA});

    // Reset in the middle of HOLD (rr_ptr=3 so requester 1 wins via wrap)
    data = 16'h0050;
    req = 4'b0010;
    step();
    check("pre_rst_ack", ack, 4'b0010);
    check("pre_rst_D", ff_D, 4'h5);
    req = 4'b0000;
    repeat (3) step();   // hold_cnt now 5
    #2;
    reset = 1'b1;
    #1;
    check("async_rst", {ack, ff_enable, ff_D, busy, last_src}, 13'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 2; n++) begin
      step();
      check("post_rst", {ack, busy, ff_enable}, 6'd0);
    end

    // All four request; rr_ptr back at 0 after reset
    data = 16'h4321;
    req = 4'b1111;
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(ok);
      check("all_timeout", ok, 1'b1);
      exp_ack = 4'b0001 << k;
      check("all_ack", ack, exp_ack);
      check("all_D", ff_D, 4'(k + 1));
      check("all_src", last_src, 3'(k));
      if (k > 0) check("all_spacing", cyc - last_cyc, 10);
      last_cyc = cyc;
      req[k] = 1'b0;
    end

    // Round-robin wrap after grant to 3
    data = 16'h7BC6;
    req = 4'b1001;
    wait_ack(ok);
    check("wrap_timeout", ok, 1'b1);
    check("wrap_ack", ack, 4'b0001);
    check("wrap_D", ff_D, 4'h6);
    check("wrap_spacing", cyc - last_cyc, 10);
    last_cyc = cyc;
    req = 4'b1001;       // requester 0 re-requests, requester 3 still waiting
    wait_ack(ok);
    check("rr_timeout", ok, 1'b1);
    check("rr_ack", ack, 4'b1000);
    check("rr_D", ff_D, 4'h7);
    check("rr_src", last_src, 3'd3);
    check("rr_spacing", cyc - last_cyc, 10);
    req = 4'b0000;

    // Request rising during HOLD at hold_cnt=4
    repeat (4) step();
    data = 16'h7BE6;
    req = 4'b0010;
    for (int n = 0; n < 4; n++) begin
      step();
      check("hold_block", {busy, ack, ff_D}, {1'b1, 4'b0000, 4'h7});
    end
    step();
    check("hold_end", {busy, ack, ff_D}, {1'b0, 4'b0000, 4'h7});
    step();
    check("late_ack", ack, 4'b0010);
    check("late_D", ff_D, 4'hE);
    check("late_en", ff_enable, 1'b1);
    req = 4'b0000;

    // Zero-hold build: continuous req on 0 and 1 alternates every 2 cycles
    data0 = 16'h0021;
    req0 = 4'b0011;
    for (int n = 0; n < 8; n++) begin
      step();
      if ((n % 2) == 0) begin
        if (((n / 2) % 2) == 0)
          check("h0_grant0", {ack0, en0, busy0, d0, src0}, {4'b0001, 1'b1, 1'b1, 4'h1, 3'd0});
        else
          check("h0_grant1", {ack0, en0, busy0, d0, src0}, {4'b0010, 1'b1, 1'b1, 4'h2, 3'd1});
      end else begin
        check("h0_idle", {ack0, en0, busy0}, 6'd0);
      end
    end
    req0 = 4'b0000;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
